// File: rtl/simon_sequencer.sv
// Simon-style memory game sequencer: plays back a growing colour sequence and checks presses.
// Define SIMON_TIMEOUT_EN to add an input timeout in WAIT_IN (TIMEOUT_TICKS cycles -> lose).
module simon_sequencer #(
    parameter int unsigned NUM_COLORS    = 4,
    parameter int unsigned MAX_LEN       = 8,
    parameter int unsigned SHOW_TICKS    = 4,
    parameter int unsigned GAP_TICKS     = 2,
    parameter int unsigned TIMEOUT_TICKS = 64,
    localparam int unsigned COLOR_W      = $clog2(NUM_COLORS),
    localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [MAX_LEN*COLOR_W-1:0] seq_data,
    input  logic [LEN_W-1:0]           seq_len,
    input  logic                       btn_valid,
    input  logic [COLOR_W-1:0]         btn_color,
    output logic [NUM_COLORS-1:0]      led,
    output logic                       busy,
    output logic                       input_ready,
    output logic [LEN_W-1:0]           level,
    output logic                       win,
    output logic                       lose
);

    localparam int unsigned MAX_TICKS = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);

    if (NUM_COLORS < 2 || NUM_COLORS > 16 || MAX_LEN < 1 || MAX_LEN > 32 ||
        SHOW_TICKS < 1 || GAP_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_param_check
        $error("simon_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        StIdle,
        StShowOn,
        StShowOff,
        StWaitIn,
        StWin,
        StLose
    } state_e;

    state_e                     state_q;
    logic [MAX_LEN*COLOR_W-1:0] seq_q;
    logic [LEN_W-1:0]           len_q;
    logic [LEN_W-1:0]           play_idx_q;
    logic [LEN_W-1:0]           in_idx_q;
    logic [TICK_W-1:0]          tick_q;

    logic [LEN_W-1:0]   cap_len;
    logic [COLOR_W-1:0] first_color;
    logic [COLOR_W-1:0] next_color;
    logic [COLOR_W-1:0] in_color;
    logic               btn_match;

    function automatic logic [COLOR_W-1:0] elem_at(input logic [MAX_LEN*COLOR_W-1:0] data,
                                                   input logic [LEN_W-1:0] idx);
        logic [COLOR_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == LEN_W'(i)) r = data[i*COLOR_W +: COLOR_W];
        end
        return r;
    endfunction

    function automatic logic [NUM_COLORS-1:0] onehot(input logic [COLOR_W-1:0] c);
        logic [NUM_COLORS-1:0] r;
        for (int i = 0; i < NUM_COLORS; i++) r[i] = (c == COLOR_W'(i));
        return r;
    endfunction

    always_comb begin
        cap_len = seq_len;
        if (seq_len == '0) begin
            cap_len = LEN_W'(1);
        end else if (seq_len > LEN_W'(MAX_LEN)) begin
            cap_len = LEN_W'(MAX_LEN);
        end
        first_color = elem_at(seq_q, '0);
        next_color  = elem_at(seq_q, play_idx_q + 1'b1);
        in_color    = elem_at(seq_q, in_idx_q);
        // Out-of-range colour codes never match, even if the stored element is also out of range.
        btn_match   = ({1'b0, btn_color} < (COLOR_W + 1)'(NUM_COLORS)) && (btn_color == in_color);
    end

    assign busy        = (state_q != StIdle);
    assign input_ready = (state_q == StWaitIn);
    assign win         = (state_q == StWin);
    assign lose        = (state_q == StLose);

`ifdef SIMON_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= StIdle;
            seq_q      <= '0;
            len_q      <= '0;
            play_idx_q <= '0;
            in_idx_q   <= '0;
            tick_q     <= '0;
            led        <= '0;
            level      <= '0;
`ifdef SIMON_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        seq_q      <= seq_data;
                        len_q      <= cap_len;
                        level      <= LEN_W'(1);
                        play_idx_q <= '0;
                        tick_q     <= '0;
                        led        <= onehot(seq_data[COLOR_W-1:0]);
                        state_q    <= StShowOn;
                    end
                end
                StShowOn: begin
                    if (tick_q == TICK_W'(SHOW_TICKS - 1)) begin
                        tick_q  <= '0;
                        led     <= '0;
                        state_q <= StShowOff;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                StShowOff: begin
                    if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
                        tick_q <= '0;
                        if (play_idx_q == level - 1'b1) begin
                            in_idx_q <= '0;
`ifdef SIMON_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                            state_q  <= StWaitIn;
                        end else begin
                            play_idx_q <= play_idx_q + 1'b1;
                            led        <= onehot(next_color);
                            state_q    <= StShowOn;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                StWaitIn: begin
                    if (btn_valid) begin
`ifdef SIMON_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        if (!btn_match) begin
                            state_q <= StLose;
                        end else if (in_idx_q != level - 1'b1) begin
                            in_idx_q <= in_idx_q + 1'b1;
                        end else if (level == len_q) begin
                            state_q <= StWin;
                        end else begin
                            level      <= level + 1'b1;
                            play_idx_q <= '0;
                            tick_q     <= '0;
                            led        <= onehot(first_color);
                            state_q    <= StShowOn;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                        state_q <= StLose;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                StWin, StLose: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 4, number of colour channels (2..16); COLOR_W = clog2(NUM_COLORS).
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum sequence length (1..32); LEN_W = clog2(MAX_LEN+1).
REQ-003 SHALL have parameter SHOW_TICKS, default 4, cycles each colour is lit during playback (>=1).
REQ-004 SHALL have parameter GAP_TICKS, default 2, dark cycles after each lit colour (>=1).
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 64, input timeout in cycles, used only under SIMON_TIMEOUT_EN.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 resetn  input  1  reset, synchronous, active-high (1 = reset).
REQ-008 start  input  1  begin game; sampled only in IDLE.
REQ-009 seq_data  input  MAX_LEN*COLOR_W  colour sequence; element i at bits [i*COLOR_W +: COLOR_W]; captured on accepted start.
REQ-010 seq_len  input  LEN_W  game length; captured on accepted start.
REQ-011 btn_valid  input  1  one-cycle player press strobe.
REQ-012 btn_color  input  COLOR_W  colour of press, valid with btn_valid.
REQ-013 led  output  NUM_COLORS  one-hot playback display; all zero outside SHOW_ON.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 input_ready  output  1  high only in WAIT_IN.
REQ-016 level  output  LEN_W  current round (number of colours shown this round).
REQ-017 win  output  1  one-cycle pulse, game completed.
REQ-018 lose  output  1  one-cycle pulse, game failed.

Function
REQ-019 SHALL implement states IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
REQ-020 IDLE: start=1 SHALL capture seq_data/seq_len, set level=1, play index=0, go to SHOW_ON next cycle.
REQ-021 Captured seq_len=0 SHALL be treated as 1; seq_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-022 SHOW_ON SHALL drive led one-hot of element[play index] for exactly SHOW_TICKS cycles, then SHOW_OFF.
REQ-023 SHOW_OFF SHALL hold led=0 for exactly GAP_TICKS cycles; then if play index==level-1 go to WAIT_IN with input index=0, else increment play index and return to SHOW_ON.
REQ-024 WAIT_IN: btn_valid with btn_color==element[input index] SHALL be a match; any other value, including btn_color>=NUM_COLORS, SHALL be a mismatch.
REQ-025 Mismatch SHALL go to LOSE on the next cycle.
REQ-026 Match with input index<level-1 SHALL increment input index and remain in WAIT_IN.
REQ-027 Match with input index==level-1 and level==captured length SHALL go to WIN; otherwise level SHALL increment, play index clear, and state go to SHOW_ON.
REQ-028 WIN/LOSE SHALL last one cycle, assert win/lose respectively during it, then return to IDLE; level SHALL hold its final value until the next accepted start.
REQ-029 btn_valid outside WAIT_IN and start outside IDLE SHALL be ignored with no state change.
REQ-030 Simultaneous start and btn_valid in IDLE SHALL accept start and discard the press.
REQ-031 win and lose SHALL never be asserted in the same cycle.

Reset
REQ-032 resetn=1 at a clock edge SHALL force IDLE, led=0, busy=0, input_ready=0, level=0, win=0, lose=0, all indices and tick counters=0, regardless of current state.
REQ-033 Reset mid-game SHALL abandon the game without a win or lose pulse; captured sequence contents are don't-care after reset.

Configuration
REQ-034 With SIMON_TIMEOUT_EN defined, a counter SHALL clear on WAIT_IN entry and on every btn_valid, and reaching TIMEOUT_TICKS cycles without a press SHALL go to LOSE.
REQ-035 Without SIMON_TIMEOUT_EN, WAIT_IN SHALL wait indefinitely and no timeout logic SHALL be synthesised.

Verification
REQ-036 Defaults, seq_data elements {2,0,3}, seq_len=3, correct presses each round -> led shows 1,2,3 colours per round (SHOW_TICKS=4 lit, GAP_TICKS=2 dark), level reaches 3, win pulses once, then IDLE.
REQ-037 Same sequence, round 2 second press btn_color=1 (expected 0) -> lose pulse next cycle, win never asserted.
REQ-038 seq_len=0, element0=3, press 3 -> treated as length 1, led=4'b1000 for 4 cycles, win pulses.
REQ-039 resetn=1 during SHOW_ON of round 2 -> next cycle busy=0, led=0, level=0, no win/lose; following start replays from level 1.
REQ-040 btn_valid during SHOW_ON and start during WAIT_IN -> ignored; sequence and indices unchanged.
REQ-041 SIMON_TIMEOUT_EN defined, TIMEOUT_TICKS=64, no press after entering WAIT_IN -> lose pulses 64 cycles after entry; without macro, still in WAIT_IN after 1000 cycles.
